seq_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter: emits a programmable WIDTH-bit pattern MSB-first, one bit/clk,

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_down_counter.sv | 25 ++
 rtl/seq_pattern_tx.sv | 149 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence transmit/detect blocks.
package seq_pkg;

   localparam int FRAME_W = 8;
   localparam int GAP_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that holds at zero, with a zero flag.
module seq_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: WIDTH-bit pattern MSB-first, repeated for N frames
// with GAP idle cycles between frames. All outputs registered.
//
//  state    | meaning
//  ST_IDLE  | waiting for start; pattern register writable
//  ST_SHIFT | dout carries pattern[bit_cnt]
//  ST_GAP   | inter-frame idle, busy still high
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int               WIDTH    = 5,
   parameter logic [WIDTH-1:0] PATTERN  = 5'b11011,
   parameter int               GAP      = 1,
   parameter logic             IDLE_BIT = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_en,
   input  logic [WIDTH-1:0]   load_pat,
   input  logic               start,
   input  logic [FRAME_W-1:0] frames,
   input  logic               abort,
   output logic               dout,
   output logic               dout_valid,
   output logic               frame_sop,
   output logic               busy,
   output logic               done
);

   localparam int                BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0]     MSB_IDX = BW'(WIDTH - 1);
   localparam logic [GAP_W-1:0]  GAP_LD  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

   seq_state_t         state_q, state_d;
   logic [WIDTH-1:0]   pattern_q, pat_eff;
   logic [BW-1:0]      bit_cnt, bit_idx;
   logic [GAP_W-1:0]   gap_cnt;
   logic [FRAME_W-1:0] frame_cnt, frame_ld_val;
   logic               bit_zero, gap_zero, frame_zero;
   logic               bit_load, bit_dec, gap_load, gap_dec, frame_load, frame_dec;
   logic               new_frame, idle_load;
   logic               dout_d, dout_valid_d, frame_sop_d, busy_d, done_d;
   logic               unused_cnt_bits;

   // A load in the same idle cycle as start must already feed the first bit.
   assign idle_load = load_en && (state_q == ST_IDLE);
   assign pat_eff   = idle_load ? load_pat : pattern_q;

   // frame_cnt holds frames still to send after the current one.
   assign frame_ld_val = (frames > FRAME_W'(1)) ? frames - FRAME_W'(1) : '0;

   assign unused_cnt_bits = ^{gap_cnt, frame_cnt};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pattern_q  <= PATTERN;
         dout       <= IDLE_BIT;
         dout_valid <= 1'b0;
         frame_sop  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         if (idle_load)
            pattern_q <= load_pat;
         dout       <= dout_d;
         dout_valid <= dout_valid_d;
         frame_sop  <= frame_sop_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (start)
               state_d = ST_SHIFT;
         ST_SHIFT:
            if (abort)
               state_d = ST_IDLE;
            else if (bit_zero) begin
               if (frame_zero)
                  state_d = ST_IDLE;
               else if (GAP > 0)
                  state_d = ST_GAP;
               else
                  state_d = ST_SHIFT;
            end
         ST_GAP:
            if (abort)
               state_d = ST_IDLE;
            else if (gap_zero)
               state_d = ST_SHIFT;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      new_frame    = (state_d == ST_SHIFT) && ((state_q != ST_SHIFT) || bit_zero);
      bit_idx      = new_frame ? MSB_IDX : bit_cnt - BW'(1);
      dout_valid_d = (state_d == ST_SHIFT);
      dout_d       = dout_valid_d ? pat_eff[bit_idx] : IDLE_BIT;
      frame_sop_d  = new_frame;
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_q == ST_SHIFT) && !abort && bit_zero && frame_zero;

      bit_load     = new_frame;
      bit_dec      = (state_q == ST_SHIFT) && !new_frame;
      frame_load   = (state_q == ST_IDLE) && start;
      frame_dec    = (state_q == ST_SHIFT) && bit_zero && !abort;
      gap_load     = (state_d == ST_GAP) && (state_q != ST_GAP);
      gap_dec      = (state_q == ST_GAP);
   end

   seq_down_counter #(.W(BW)) u_bit_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (bit_load),
      .load_val (MSB_IDX),
      .dec      (bit_dec),
      .cnt      (bit_cnt),
      .zero     (bit_zero)
   );

   seq_down_counter #(.W(GAP_W)) u_gap_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (gap_load),
      .load_val (GAP_LD),
      .dec      (gap_dec),
      .cnt      (gap_cnt),
      .zero     (gap_zero)
   );

   seq_down_counter #(.W(FRAME_W)) u_frame_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (frame_load),
      .load_val (frame_ld_val),
      .dec      (frame_dec),
      .cnt      (frame_cnt),
      .zero     (frame_zero)
   );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed scoreboard bench for seq_pattern_tx (GAP=1 instance plus a GAP=0 instance).
module tb_seq_pattern_tx;

   localparam logic [4:0] E_GAP  = 5'b00010;   // {dout,valid,sop,busy,done}
   localparam logic [4:0] E_DONE = 5'b00001;
   localparam logic [4:0] E_IDLE = 5'b00000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_en = 1'b0, start = 1'b0, abort = 1'b0;
   logic       load_en1 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
   logic [4:0] load_pat = 5'b00000;
   logic [7:0] frames = 8'd0;

   logic dout0, valid0, sop0, busy0, done0;
   logic dout1, valid1, sop1, busy1, done1;

   logic [4:0] q0[$], q1[$];
   string      t0[$], t1[$];
   int         compared = 0, mismatched = 0;
   int         busy_cnt = 0, done_cnt = 0, match_cnt = 0, det_fill = 0;
   logic [4:0] det_hist = 5'b00000;
   int         b0, d0, m0;

   always #5 clk = ~clk;

   seq_pattern_tx #(.WIDTH(5), .PATTERN(5'b11011), .GAP(1), .IDLE_BIT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_pat(load_pat), .start(start),
      .frames(frames), .abort(abort), .dout(dout0), .dout_valid(valid0),
      .frame_sop(sop0), .busy(busy0), .done(done0)
   );

   seq_pattern_tx #(.WIDTH(5), .PATTERN(5'b11011), .GAP(0), .IDLE_BIT(1'b0)) u_dut_gap0 (
      .clk(clk), .rst(rst), .load_en(load_en1), .load_pat(load_pat), .start(start1),
      .frames(frames), .abort(abort1), .dout(dout1), .dout_valid(valid1),
      .frame_sop(sop1), .busy(busy1), .done(done1)
   );

   task automatic push(input int which, input logic [4:0] e, input string tag);
      if (which == 0) begin q0.push_back(e); t0.push_back(tag); end
      else            begin q1.push_back(e); t1.push_back(tag); end
   endtask

   task automatic push_frame(input int which, input logic [4:0] pat, input string tag);
      for (int i = 4; i >= 0; i--)
         push(which, {pat[i], 1'b1, (i == 4), 1'b1, 1'b0}, tag);
   endtask

   task automatic check(input logic [4:0] obs, input logic [4:0] exp, input string tag);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b (dout,valid,sop,busy,done)", tag, obs, exp);
      end
   endtask

   task automatic check_int(input int obs, input int exp, input string tag);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: sample after the edge, score, then return at the falling edge.
   task automatic tick();
      logic [4:0] e;
      string      tg;
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
         e = q0.pop_front(); tg = t0.pop_front();
         check({dout0, valid0, sop0, busy0, done0}, e, tg);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front(); tg = t1.pop_front();
         check({dout1, valid1, sop1, busy1, done1}, e, tg);
      end
      if (busy0) busy_cnt++;
      if (done0) done_cnt++;
      if (valid0) begin
         det_hist = {det_hist[3:0], dout0};
         if (det_fill < 5) det_fill++;
         if (det_fill >= 5 && det_hist == 5'b11011) match_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic pulse_start(input logic [7:0] f);
      start  = 1'b1;
      frames = f;
      tick();
      start  = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++)
         tick();
      check_int(q0.size() + q1.size(), 0, tag);
   endtask

   task automatic snap();
      b0 = busy_cnt; d0 = done_cnt; m0 = match_cnt;
   endtask

   initial begin
      // reset
      for (int i = 0; i < 3; i++) begin
         push(0, E_IDLE, "reset0");
         push(1, E_IDLE, "reset1");
      end
      repeat (3) tick();
      rst = 1'b0;

      // single frame, default pattern
      snap();
      push_frame(0, 5'b11011, "f1_bits");
      push(0, E_DONE, "f1_done");
      push(0, E_IDLE, "f1_after");
      pulse_start(8'd1);
      drain("f1_drain");
      check_int(busy_cnt - b0, 5, "f1_busy_cycles");
      check_int(done_cnt - d0, 1, "f1_done_count");

      // three frames with one gap cycle, loopback detector
      snap();
      push_frame(0, 5'b11011, "f3_fr1"); push(0, E_GAP, "f3_gap1");
      push_frame(0, 5'b11011, "f3_fr2"); push(0, E_GAP, "f3_gap2");
      push_frame(0, 5'b11011, "f3_fr3");
      push(0, E_DONE, "f3_done");
      push(0, E_IDLE, "f3_after");
      pulse_start(8'd3);
      drain("f3_drain");
      check_int(busy_cnt - b0, 17, "f3_busy_cycles");
      check_int(done_cnt - d0, 1, "f3_done_count");
      check_int(match_cnt - m0, 3, "f3_detector_matches");

      // back-to-back frames on the GAP=0 instance
      push_frame(1, 5'b11011, "g0_fr1");
      push_frame(1, 5'b11011, "g0_fr2");
      push(1, E_DONE, "g0_done");
      push(1, E_IDLE, "g0_after");
      start1 = 1'b1; frames = 8'd2;
      tick();
      start1 = 1'b0;
      drain("g0_drain");

      // load and start in the same idle cycle
      push_frame(0, 5'b10110, "ld_bits");
      push(0, E_DONE, "ld_done");
      push(0, E_IDLE, "ld_after");
      load_en = 1'b1; load_pat = 5'b10110;
      pulse_start(8'd1);
      load_en = 1'b0;
      drain("ld_drain");

      // load while busy is ignored
      push_frame(0, 5'b10110, "ldb_fr1"); push(0, E_GAP, "ldb_gap");
      push_frame(0, 5'b10110, "ldb_fr2");
      push(0, E_DONE, "ldb_done");
      push(0, E_IDLE, "ldb_after");
      pulse_start(8'd2);
      load_en = 1'b1; load_pat = 5'b11111;
      tick();
      load_en = 1'b0;
      drain("ldb_drain");

      // abort on third bit of frame 2 of 4
      snap();
      push_frame(0, 5'b10110, "ab_fr1"); push(0, E_GAP, "ab_gap");
      push(0, 5'b11110, "ab_fr2_b1");
      push(0, 5'b01010, "ab_fr2_b2");
      push(0, 5'b11010, "ab_fr2_b3");
      push(0, E_IDLE, "ab_idle1");
      push(0, E_IDLE, "ab_idle2");
      pulse_start(8'd4);
      repeat (8) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      drain("ab_drain");
      check_int(done_cnt - d0, 0, "ab_no_done");
      check_int(busy_cnt - b0, 9, "ab_busy_cycles");

      // abort while idle has no effect
      push(0, E_IDLE, "ab_in_idle");
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // reset mid-frame
      push(0, 5'b11110, "rs_b1");
      push(0, 5'b01010, "rs_b2");
      push(0, E_IDLE, "rs_reset");
      push(0, E_IDLE, "rs_idle");
      pulse_start(8'd2);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drain("rs_drain");

      // abort+start in idle: start wins; pattern register back at reset value
      push_frame(0, 5'b11011, "as_bits");
      push(0, E_DONE, "as_done");
      push(0, E_IDLE, "as_after");
      abort = 1'b1;
      pulse_start(8'd1);
      abort = 1'b0;
      drain("as_drain");

      // frames=0, start while busy, restart in the done cycle
      snap();
      push_frame(0, 5'b11011, "z_fr");
      push(0, E_DONE, "z_done");
      push_frame(0, 5'b11011, "rd_fr");
      push(0, E_DONE, "rd_done");
      push(0, E_IDLE, "rd_after");
      pulse_start(8'd0);
      start = 1'b1; frames = 8'd3;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start = 1'b1; frames = 8'd1;
      tick();
      start = 1'b0;
      drain("z_drain");
      check_int(busy_cnt - b0, 10, "z_busy_cycles");
      check_int(done_cnt - d0, 2, "z_done_count");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
